// File: rtl/booth_pkg.sv
// Shared types for the Booth multiplier datapath: sign-mode encoding and the
// per-issue sideband tag that travels alongside the core's pipeline.
package booth_pkg;

   localparam int unsigned CORE_LAT = 6;

   typedef enum logic [1:0] {
      SM_UU = 2'b00,
      SM_US = 2'b01,
      SM_SU = 2'b10,
      SM_SS = 2'b11
   } sm_e;

   typedef struct packed {
      logic v;
      sm_e  sm;
      logic last;
   } tag_t;

   localparam int unsigned TAG_W = $bits(tag_t);

   // Any mode with a signed operand yields a product to sign-extend.
   function automatic logic sm_is_signed(input sm_e sm);
      return sm != SM_UU;
   endfunction

endpackage

// File: rtl/booth_tag_delay.sv
// Fixed-depth shift register that carries issue tags through the same
// latency as the multiplier core, so the tail lines up with core_v/core_p.
module booth_tag_delay
   import booth_pkg::*;
#(
   parameter int unsigned DEPTH = booth_pkg::CORE_LAT
) (
   input  logic clk,
   input  logic rst,
   input  tag_t tag_i,
   output tag_t tag_o
);

   tag_t line_q [DEPTH];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            line_q[i] <= '0;
         end
      end else begin
         line_q[0] <= tag_i;
         for (int unsigned i = 1; i < DEPTH; i++) begin
            line_q[i] <= line_q[i-1];
         end
      end
   end

   assign tag_o = line_q[DEPTH-1];

endmodule

// File: rtl/booth_mac_accum.sv
// Group accumulator behind the radix-4 Booth core: realigns issue tags,
// sums products per group and presents one result through a valid/ready port.
module booth_mac_accum
   import booth_pkg::*;
#(
   parameter int unsigned CORE_LAT = booth_pkg::CORE_LAT,
   parameter int unsigned ACC_W    = 24,
   parameter int unsigned CNT_W    = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             issue_v,
   input  logic [1:0]       issue_sm,
   input  logic             issue_last,
   input  logic             core_v,
   input  logic [15:0]      core_p,
   output logic             acc_valid,
   input  logic             acc_ready,
   output logic [ACC_W-1:0] acc_sum,
   output logic [CNT_W-1:0] acc_cnt,
   output logic             acc_ovf,
   output logic             err_drop,
   output logic             err_align
);

   localparam int unsigned FL_W = $clog2(CORE_LAT + 1);

   tag_t tag_in;
   tag_t tail;

   logic [FL_W-1:0]  flush_q, flush_d;
   logic             in_flush;

   logic [ACC_W-1:0] acc_q, acc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             govf_q, govf_d;

   logic             out_valid_q, out_valid_d;
   logic [ACC_W-1:0] out_sum_q, out_sum_d;
   logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
   logic             out_ovf_q, out_ovf_d;

   logic             drop_q, drop_d;
   logic             align_q, align_d;

   logic [ACC_W-1:0] ext;
   logic [ACC_W-1:0] sum_n;
   logic [CNT_W-1:0] cnt_n;
   logic             add_ovf;
   logic             govf_n;

   always_comb begin
      tag_in      = '0;
      tag_in.v    = issue_v;
      tag_in.sm   = sm_e'(issue_sm);
      tag_in.last = issue_last;
   end

   booth_tag_delay #(
      .DEPTH (CORE_LAT)
   ) u_tag_delay (
      .clk   (clk),
      .rst   (rst),
      .tag_i (tag_in),
      .tag_o (tail)
   );

   // The core has no reset, so its valid pipe is untrusted until it has drained.
   assign in_flush = flush_q < FL_W'(CORE_LAT);

   always_comb begin
      ext = sm_is_signed(tail.sm) ? {{(ACC_W-16){core_p[15]}}, core_p}
                                  : {{(ACC_W-16){1'b0}}, core_p};
      sum_n   = acc_q + ext;
      add_ovf = (acc_q[ACC_W-1] == ext[ACC_W-1]) && (sum_n[ACC_W-1] != acc_q[ACC_W-1]);
      govf_n  = govf_q | add_ovf;
      cnt_n   = cnt_q + CNT_W'(1);
   end

   always_comb begin
      flush_d     = in_flush ? flush_q + FL_W'(1) : flush_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      govf_d      = govf_q;
      out_valid_d = out_valid_q;
      out_sum_d   = out_sum_q;
      out_cnt_d   = out_cnt_q;
      out_ovf_d   = out_ovf_q;
      drop_d      = drop_q;
      align_d     = align_q;

      if (!in_flush && (tail.v != core_v)) begin
         align_d = 1'b1;
      end

      if (tail.v && !tail.last) begin
         acc_d  = sum_n;
         cnt_d  = cnt_n;
         govf_d = govf_n;
      end

      // A closing beat always clears the group, whether or not its result fits.
      if (tail.v && tail.last) begin
         acc_d  = '0;
         cnt_d  = '0;
         govf_d = 1'b0;
         if (!out_valid_q || acc_ready) begin
            out_valid_d = 1'b1;
            out_sum_d   = sum_n;
            out_cnt_d   = cnt_n;
            out_ovf_d   = govf_n;
         end else begin
            drop_d = 1'b1;
         end
      end else if (out_valid_q && acc_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         flush_q     <= '0;
         acc_q       <= '0;
         cnt_q       <= '0;
         govf_q      <= 1'b0;
         out_valid_q <= 1'b0;
         out_sum_q   <= '0;
         out_cnt_q   <= '0;
         out_ovf_q   <= 1'b0;
         drop_q      <= 1'b0;
         align_q     <= 1'b0;
      end else begin
         flush_q     <= flush_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         govf_q      <= govf_d;
         out_valid_q <= out_valid_d;
         out_sum_q   <= out_sum_d;
         out_cnt_q   <= out_cnt_d;
         out_ovf_q   <= out_ovf_d;
         drop_q      <= drop_d;
         align_q     <= align_d;
      end
   end

   assign acc_valid = out_valid_q;
   assign acc_sum   = out_sum_q;
   assign acc_cnt   = out_cnt_q;
   assign acc_ovf   = out_ovf_q;
   assign err_drop  = drop_q;
   assign err_align = align_q;

endmodule

// File: tb/tb_booth_mac_accum.sv
// Bench for booth_mac_accum: a behavioural stand-in for the Booth core feeds
// the block, and a group-level model predicts every output cycle by cycle.
module tb_booth_mac_accum;

   localparam int unsigned LAT   = 6;
   localparam int unsigned ACC_W = 24;
   localparam int unsigned CNT_W = 8;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             issue_v = 1'b0;
   logic [1:0]       issue_sm = 2'b00;
   logic             issue_last = 1'b0;
   logic             core_v = 1'b0;
   logic [15:0]      core_p = '0;
   logic             acc_ready = 1'b1;
   logic             acc_valid;
   logic [ACC_W-1:0] acc_sum;
   logic [CNT_W-1:0] acc_cnt;
   logic             acc_ovf;
   logic             err_drop;
   logic             err_align;

   logic [7:0]  op_a = '0;
   logic [7:0]  op_b = '0;
   logic        stray = 1'b0;
   logic        started = 1'b0;
   logic        pv [LAT];
   logic [15:0] pp [LAT];

   int errors = 0;
   int checks = 0;

   booth_mac_accum #(
      .CORE_LAT (LAT),
      .ACC_W    (ACC_W),
      .CNT_W    (CNT_W)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .issue_v    (issue_v),
      .issue_sm   (issue_sm),
      .issue_last (issue_last),
      .core_v     (core_v),
      .core_p     (core_p),
      .acc_valid  (acc_valid),
      .acc_ready  (acc_ready),
      .acc_sum    (acc_sum),
      .acc_cnt    (acc_cnt),
      .acc_ovf    (acc_ovf),
      .err_drop   (err_drop),
      .err_align  (err_align)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] prod(input logic [1:0] sm, input logic [7:0] a, input logic [7:0] b);
      int av, bv;
      av = (sm[1] && a[7]) ? int'(a) - 256 : int'(a);
      bv = (sm[0] && b[7]) ? int'(b) - 256 : int'(b);
      return 16'(av * bv);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
      end
   endtask

   // Core stand-in: unreset CORE_LAT-deep pipe advanced just after each edge.
   task automatic tick();
      @(posedge clk);
      #1;
      for (int i = LAT - 1; i > 0; i--) begin
         pv[i] = pv[i-1];
         pp[i] = pp[i-1];
      end
      pv[0]  = issue_v;
      pp[0]  = prod(issue_sm, op_a, op_b);
      core_v = pv[LAT-1] | stray;
      core_p = pp[LAT-1];
   endtask

   task automatic issue(input logic [1:0] sm, input logic [7:0] a, input logic [7:0] b, input logic last);
      issue_v    = 1'b1;
      issue_sm   = sm;
      op_a       = a;
      op_b       = b;
      issue_last = last;
      tick();
      issue_v    = 1'b0;
      issue_last = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   task automatic wait_valid(output int n);
      n = 0;
      while (acc_valid !== 1'b1 && n < 40) begin
         tick();
         n++;
      end
      chk("wait_valid_timeout", {31'b0, acc_valid}, 32'd1);
   endtask

   // ---------------- group-level reference model ----------------
   typedef struct {
      int          edge_no;
      logic [23:0] sum;
      int          cnt;
      bit          ovf;
   } res_t;

   res_t        rq[$];
   int          ecount = 0;
   int          rel_edge = 0;
   bit          hist [4096];
   int          g_acc, g_cnt;
   bit          g_ovf;
   bit          m_valid, m_ovf, m_drop, m_align;
   logic [23:0] m_sum;
   int          m_cnt;

   task automatic m_reset();
      rq.delete();
      g_acc = 0; g_cnt = 0; g_ovf = 0;
      m_valid = 0; m_ovf = 0; m_drop = 0; m_align = 0;
      m_sum = '0; m_cnt = 0;
   endtask

   always @(posedge rst) m_reset();

   always @(posedge clk) begin
      int   e, s;
      bit   exp_v;
      res_t r;
      ecount++;
      if (rst) begin
         m_reset();
         rel_edge = ecount + 1;
         hist[ecount] = 1'b0;
      end else begin
         hist[ecount] = issue_v;
         if (ecount >= rel_edge + int'(LAT)) begin
            exp_v = (ecount >= int'(LAT)) ? hist[ecount - int'(LAT)] : 1'b0;
            if (core_v != exp_v) m_align = 1;
         end
         if (rq.size() > 0 && rq[0].edge_no == ecount) begin
            r = rq.pop_front();
            if (!m_valid || acc_ready) begin
               m_valid = 1; m_sum = r.sum; m_cnt = r.cnt; m_ovf = r.ovf;
            end else begin
               m_drop = 1;
            end
         end else if (m_valid && acc_ready) begin
            m_valid = 0;
         end
         if (issue_v) begin
            logic [15:0] p;
            p = prod(issue_sm, op_a, op_b);
            e = (issue_sm == 2'b00) ? int'(p) : (p[15] ? int'(p) - 65536 : int'(p));
            s = g_acc + e;
            if (s >= (1 << 23) || s < -(1 << 23)) g_ovf = 1;
            if (s >= (1 << 23)) s -= (1 << 24);
            if (s < -(1 << 23)) s += (1 << 24);
            g_acc = s;
            g_cnt = (g_cnt + 1) % 256;
            if (issue_last) begin
               r.edge_no = ecount + int'(LAT);
               r.sum     = 24'(g_acc);
               r.cnt     = g_cnt;
               r.ovf     = g_ovf;
               rq.push_back(r);
               g_acc = 0; g_cnt = 0; g_ovf = 0;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (started) begin
         chk("cmp_valid", {31'b0, acc_valid}, {31'b0, m_valid});
         chk("cmp_err_drop", {31'b0, err_drop}, {31'b0, m_drop});
         chk("cmp_err_align", {31'b0, err_align}, {31'b0, m_align});
         if (m_valid) begin
            chk("cmp_sum", {8'b0, acc_sum}, {8'b0, m_sum});
            chk("cmp_cnt", {24'b0, acc_cnt}, 32'(m_cnt));
            chk("cmp_ovf", {31'b0, acc_ovf}, {31'b0, m_ovf});
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // ---------------- directed stimulus ----------------
   initial begin
      int n;
      for (int i = 0; i < int'(LAT); i++) begin
         pv[i] = i[0];
         pp[i] = 16'hA5A5;
      end
      #2 rst = 1'b1;
      tick();
      tick();
      chk("rst_valid", {31'b0, acc_valid}, 32'd0);
      chk("rst_sum", {8'b0, acc_sum}, 32'd0);
      chk("rst_cnt", {24'b0, acc_cnt}, 32'd0);
      chk("rst_ovf", {31'b0, acc_ovf}, 32'd0);
      chk("rst_errs", {30'b0, err_drop, err_align}, 32'd0);
      started = 1'b1;
      rst = 1'b0;

      // Unsigned: 3 x 255*255
      issue(2'b00, 8'd255, 8'd255, 1'b0);
      issue(2'b00, 8'd255, 8'd255, 1'b0);
      issue(2'b00, 8'd255, 8'd255, 1'b1);
      wait_valid(n);
      chk("latency", 32'(n), 32'(LAT));
      chk("uu_sum", {8'b0, acc_sum}, 32'd195075);
      chk("uu_cnt", {24'b0, acc_cnt}, 32'd3);
      chk("uu_ovf", {31'b0, acc_ovf}, 32'd0);
      idle(2);

      // Signed: (-128)*(-128) + (-1)*127
      issue(2'b11, 8'h80, 8'h80, 1'b0);
      issue(2'b11, 8'hFF, 8'h7F, 1'b1);
      wait_valid(n);
      chk("ss_sum", {8'b0, acc_sum}, 32'd16257);
      chk("ss_cnt", {24'b0, acc_cnt}, 32'd2);
      idle(2);

      // Signed x unsigned: (-2)*200
      issue(2'b10, 8'hFE, 8'd200, 1'b1);
      wait_valid(n);
      chk("su_sum", {8'b0, acc_sum}, 32'h00FF_FE70);
      chk("su_cnt", {24'b0, acc_cnt}, 32'd1);
      idle(2);

      // Simultaneous: held result replaced in the cycle acc_ready accepts it
      acc_ready = 1'b0;
      issue(2'b00, 8'd5, 8'd5, 1'b1);
      idle(1);
      issue(2'b00, 8'd6, 8'd6, 1'b1);
      idle(5);
      chk("sim_held_valid", {31'b0, acc_valid}, 32'd1);
      chk("sim_held_sum", {8'b0, acc_sum}, 32'd25);
      acc_ready = 1'b1;
      tick();
      acc_ready = 1'b0;
      chk("sim_new_valid", {31'b0, acc_valid}, 32'd1);
      chk("sim_new_sum", {8'b0, acc_sum}, 32'd36);
      chk("sim_no_drop", {31'b0, err_drop}, 32'd0);
      acc_ready = 1'b1;
      idle(2);

      // Backpressure: second group is lost
      acc_ready = 1'b0;
      issue(2'b00, 8'd10, 8'd10, 1'b1);
      issue(2'b00, 8'd3, 8'd3, 1'b1);
      wait_valid(n);
      chk("bp_sum", {8'b0, acc_sum}, 32'd100);
      idle(3);
      chk("bp_hold_sum", {8'b0, acc_sum}, 32'd100);
      chk("bp_hold_valid", {31'b0, acc_valid}, 32'd1);
      chk("bp_drop", {31'b0, err_drop}, 32'd1);
      acc_ready = 1'b1;
      tick();
      chk("bp_consumed", {31'b0, acc_valid}, 32'd0);
      issue(2'b00, 8'd20, 8'd20, 1'b1);
      wait_valid(n);
      chk("bp_next_sum", {8'b0, acc_sum}, 32'd400);
      idle(2);

      // Overflow: 513 x 16384 wraps past +2^23
      for (int i = 0; i < 513; i++) begin
         issue(2'b11, 8'h80, 8'h80, (i == 512) ? 1'b1 : 1'b0);
      end
      wait_valid(n);
      chk("ovf_flag", {31'b0, acc_ovf}, 32'd1);
      chk("ovf_sum", {8'b0, acc_sum}, 32'h0080_4000);
      chk("ovf_cnt", {24'b0, acc_cnt}, 32'd1);
      idle(2);

      // Reset mid-group: stray core beats fall inside the flush window
      issue(2'b11, 8'd3, 8'd4, 1'b0);
      issue(2'b11, 8'd5, 8'd6, 1'b0);
      rst = 1'b1;
      idle(2);
      rst = 1'b0;
      issue(2'b11, 8'd7, 8'hFD, 1'b0);
      issue(2'b11, 8'd2, 8'd2, 1'b1);
      wait_valid(n);
      chk("rst_mid_latency", 32'(n), 32'(LAT));
      chk("rst_mid_sum", {8'b0, acc_sum}, 32'h00FF_FFEF);
      chk("rst_mid_cnt", {24'b0, acc_cnt}, 32'd2);
      chk("rst_mid_align", {31'b0, err_align}, 32'd0);
      chk("rst_mid_drop", {31'b0, err_drop}, 32'd0);
      idle(8);

      // Stray core_v outside the window raises err_align
      stray = 1'b1;
      tick();
      stray = 1'b0;
      tick();
      chk("align_set", {31'b0, err_align}, 32'd1);
      idle(3);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
